layer_compositor: RTL and testbench
===================================

# layer_compositor

Per-pixel layer compositor and fade scheduler for the VGA render path. It takes the `rgb_t` outputs of up to `NUM_LAYERS` sprite/tile renderers plus a background colour, discards layers showing the `TRANSPARENT` key or masked off, and selects the highest-priority opaque layer. It emits one 24-bit pixel per valid input with fixed latency, feeding the VGA output register. Layer-enable configuration is double-buffered and applied only at frame boundaries, so no frame ever shows mixed configuration.

## Interface
Parameters:
- `NUM_LAYERS`, 4: number of layer inputs. Layer 0 has the highest priority.
- `FADE_STEP`, 2: frames per fade level step. Used only with fade compiled in.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse before the first active pixel of a frame.
- `pix_valid_i`  in  1  layer inputs valid this cycle.
- `layer_rgb_i`  in  `NUM_LAYERS`×24  packed `rgb_t` array. Layer k occupies bits [24k+23:24k].
- `bg_rgb_i`  in  24  background colour. Always opaque.
- `cfg_we`  in  1  write strobe for the shadow mask.
- `cfg_mask_i`  in  `NUM_LAYERS`  layer enable bits.
- `fade_cmd_i`  in  2  `01` = fade out, `10` = fade in, others = no-op. Sampled on `frame_start` only.
- `pix_valid_o`  out  1  output pixel valid.
- `pix_rgb_o`  out  24  composited pixel.
- `hit_layer_o`  out  `$clog2(NUM_LAYERS+1)`  index of the winning layer; `NUM_LAYERS` means background.
- `fade_busy_o`  out  1  high while a fade is in progress. Tied 0 without fade.

## Operation
- Shadow mask:
  - `cfg_we` loads `shadow_mask`.
  - `frame_start` copies `shadow_mask` into `active_mask`.
  - If `cfg_we` and `frame_start` occur in the same cycle, the new `cfg_mask_i` goes to both registers.
- Stage 1 (registered): `opaque[k] = active_mask[k] && (layer k != TRANSPARENT)`, where TRANSPARENT = FF00FF. The stage registers `opaque` and all RGB inputs.
- Stage 2 (registered): a lowest-index-wins priority encode over `opaque`.
  - Some bit set: output that layer's RGB; `hit` = its index.
  - No bit set: output `bg_rgb_i` (the stage-1 copy); `hit` = `NUM_LAYERS`.
- `pix_valid` is carried through every stage. When valid is 0, the data registers hold their previous value.
- No backpressure. One pixel is accepted every cycle.

## Timing
- Latency: 2 cycles with fade out, 3 cycles with fade in. `pix_valid_i` at cycle n gives `pix_valid_o` at n+2 or n+3.
- Reset values:
  - `pix_valid_o` = 0, `pix_rgb_o` = 000000, `hit_layer_o` = 0, `fade_busy_o` = 0.
  - `shadow_mask` and `active_mask` = all ones.
  - Fade level = 0, FSM in IDLE.
- Reset asserted mid-stream: the pipeline flushes immediately and `pix_valid_o` drops asynchronously. The first valid pixel after reset deassert appears after the full latency.
- A `frame_start` pulse affects the pixel presented in the same cycle. Mask changes take effect on that pixel.

## Configuration
- `LAYER_FADE_EN` defined:
  - Adds a stage-3 brightness scaler: each channel becomes `(c × (8 − level)) >> 3`, with `level` in 0..8.
  - Adds the fade FSM with states IDLE, FADE_OUT, DARK, FADE_IN:
    - IDLE + `fade_cmd_i` `01` at `frame_start` → FADE_OUT.
    - FADE_OUT: `level` increments once every `FADE_STEP` frame_starts. On reaching 8 → DARK.
    - DARK + `10` → FADE_IN.
    - FADE_IN: `level` decrements at the same rate. On reaching 0 → IDLE.
    - Commands received in FADE_OUT or FADE_IN are ignored.
  - The frame-step counter resets when the FSM enters a fade state.
  - `fade_busy_o` is high in FADE_OUT and FADE_IN.
  - Intermediate product width is 12 bits. No rounding; truncate.
- `LAYER_FADE_EN` undefined: no stage 3, no FSM, latency 2, and `fade_cmd_i` is ignored.

## Structure
- `color_pkg` adds:
  - `rgb_layers_t` (packed array of `rgb_t`)
  - a `FADE_LEVEL_MAX = 8` constant
  - a `fade_state_t` enum
- `TRANSPARENT` is taken from the package, never hard-coded in the RTL.
- One sub-module, `layer_priority_enc`: combinational one-hot/first-set encoder producing the index plus a hit flag. Shared with future collision logic.

## Test plan
- Layer0 = FF00FF, layer1 = E74C3C, layers 2–3 = FFCC00, mask 1111 → at n+2 `pix_rgb_o` = E74C3C, `hit_layer_o` = 1.
- All layers FF00FF, `bg_rgb_i` = 87CEEB → `pix_rgb_o` = 87CEEB, `hit_layer_o` = 4.
- Mid-frame `cfg_we` with mask 1110; layer0 = 7FC83F and layer1 = 55A02F throughout:
  - before the next `frame_start`: output stays 7FC83F;
  - from the pixel coincident with `frame_start`: output is 55A02F, hit = 1.
- Reset pulse during a continuous valid stream → `pix_valid_o` = 0 immediately. After release, valid returns exactly the pipeline latency after the first `pix_valid_i`. Mask reads back as 1111.
- With `LAYER_FADE_EN`, `FADE_STEP` = 2, fade out started, winning layer E74C3C:
  - after 8 frame_starts (level 4): output = 73261E;
  - after 16 frame_starts: output = 000000, FSM in DARK, `fade_busy_o` = 0.
- With `LAYER_FADE_EN`: `10` issued in DARK → level returns to 0 after 16 frame_starts, output = E74C3C. A `01` command issued during FADE_IN is ignored.

Source files
------------

// File: rtl/color_pkg.sv
// Shared colour types and constants for the VGA render path: pixel type,
// transparency key, fade levels and the fade FSM encoding.
package color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t TRANSPARENT = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

    localparam int LAYERS_DEFAULT = 4;
    typedef rgb_t [LAYERS_DEFAULT-1:0] rgb_layers_t;

    localparam int FADE_LEVEL_MAX = 8;

    localparam logic [1:0] CMD_FADE_OUT = 2'b01;
    localparam logic [1:0] CMD_FADE_IN  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        DARK     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // Each channel becomes (c * (8 - level)) >> 3 with a 12-bit product, truncated.
    function automatic rgb_t scale_rgb(input rgb_t c, input logic [3:0] level);
        logic [11:0] mult;
        rgb_t        s;
        mult = 12'(FADE_LEVEL_MAX) - 12'(level);
        s.r  = 8'((12'(c.r) * mult) >> 3);
        s.g  = 8'((12'(c.g) * mult) >> 3);
        s.b  = 8'((12'(c.b) * mult) >> 3);
        return s;
    endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// First-set (lowest index wins) encoder. Returns the index of the first set
// request bit plus a hit flag; with no request the index is N.
module layer_priority_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]               req,
    output logic [$clog2(N+1)-1:0]     idx,
    output logic                       hit
);

    localparam int IDX_W = $clog2(N+1);

    always_comb begin
        idx = IDX_W'(N);
        hit = 1'b0;
        // Walk from the top so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Per-pixel layer compositor with frame-synchronous layer masks.
// Optional fade scaler and FSM compiled in with `define LAYER_FADE_EN.
module layer_compositor
    import color_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int FADE_STEP  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_start,
    input  logic                              pix_valid_i,
    input  rgb_t [NUM_LAYERS-1:0]             layer_rgb_i,
    input  rgb_t                              bg_rgb_i,
    input  logic                              cfg_we,
    input  logic [NUM_LAYERS-1:0]             cfg_mask_i,
    input  logic [1:0]                        fade_cmd_i,
    output logic                              pix_valid_o,
    output rgb_t                              pix_rgb_o,
    output logic [$clog2(NUM_LAYERS+1)-1:0]   hit_layer_o,
    output logic                              fade_busy_o
);

    localparam int HIT_W = $clog2(NUM_LAYERS+1);

    logic [NUM_LAYERS-1:0] shadow_mask_reg;
    logic [NUM_LAYERS-1:0] active_mask_reg;
    logic [NUM_LAYERS-1:0] eff_mask;
    logic [NUM_LAYERS-1:0] opaque_next;

    logic                  valid1_reg;
    logic [NUM_LAYERS-1:0] opaque1_reg;
    rgb_t [NUM_LAYERS-1:0] layers1_reg;
    rgb_t                  bg1_reg;

    logic [HIT_W-1:0]      enc_idx;
    logic                  enc_hit;
    rgb_t                  sel_rgb;

    logic                  valid2_reg;
    rgb_t                  rgb2_reg;
    logic [HIT_W-1:0]      hit2_reg;

    // The pixel coincident with frame_start already sees the new mask.
    always_comb begin
        eff_mask = active_mask_reg;
        if (frame_start)
            eff_mask = cfg_we ? cfg_mask_i : shadow_mask_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_mask_reg <= '1;
            active_mask_reg <= '1;
        end else begin
            if (cfg_we)
                shadow_mask_reg <= cfg_mask_i;
            if (frame_start)
                active_mask_reg <= eff_mask;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
            assign opaque_next[gi] = eff_mask[gi] && (layer_rgb_i[gi] != TRANSPARENT);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1_reg  <= 1'b0;
            opaque1_reg <= '0;
            layers1_reg <= '0;
            bg1_reg     <= '0;
        end else begin
            valid1_reg <= pix_valid_i;
            if (pix_valid_i) begin
                opaque1_reg <= opaque_next;
                layers1_reg <= layer_rgb_i;
                bg1_reg     <= bg_rgb_i;
            end
        end
    end

    layer_priority_enc #(
        .N (NUM_LAYERS)
    ) u_prio (
        .req (opaque1_reg),
        .idx (enc_idx),
        .hit (enc_hit)
    );

    always_comb begin
        sel_rgb = bg1_reg;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (enc_hit && enc_idx == HIT_W'(k))
                sel_rgb = layers1_reg[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid2_reg <= 1'b0;
            rgb2_reg   <= '0;
            hit2_reg   <= '0;
        end else begin
            valid2_reg <= valid1_reg;
            if (valid1_reg) begin
                rgb2_reg <= sel_rgb;
                hit2_reg <= enc_idx;
            end
        end
    end

`ifdef LAYER_FADE_EN
    localparam int CNT_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

    fade_state_t      state_reg, state_next;
    logic [3:0]       level_reg, level_next;
    logic [CNT_W-1:0] step_cnt_reg, step_cnt_next;

    logic             valid3_reg;
    rgb_t             rgb3_reg;
    logic [HIT_W-1:0] hit3_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            level_reg    <= '0;
            step_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            step_cnt_reg <= step_cnt_next;
        end
    end

    // Everything advances only on frame_start; commands mid-fade are dropped.
    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        step_cnt_next = step_cnt_reg;
        if (frame_start) begin
            case (state_reg)
                IDLE: begin
                    if (fade_cmd_i == CMD_FADE_OUT) begin
                        state_next    = FADE_OUT;
                        step_cnt_next = '0;
                    end
                end
                FADE_OUT: begin
                    if (step_cnt_reg == CNT_W'(FADE_STEP - 1)) begin
                        step_cnt_next = '0;
                        level_next    = level_reg + 4'd1;
                        if (level_reg == 4'(FADE_LEVEL_MAX - 1))
                            state_next = DARK;
                    end else begin
                        step_cnt_next = step_cnt_reg + CNT_W'(1);
                    end
                end
                DARK: begin
                    if (fade_cmd_i == CMD_FADE_IN) begin
                        state_next    = FADE_IN;
                        step_cnt_next = '0;
                    end
                end
                FADE_IN: begin
                    if (step_cnt_reg == CNT_W'(FADE_STEP - 1)) begin
                        step_cnt_next = '0;
                        level_next    = level_reg - 4'd1;
                        if (level_reg == 4'd1)
                            state_next = IDLE;
                    end else begin
                        step_cnt_next = step_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        fade_busy_o = (state_reg == FADE_OUT) || (state_reg == FADE_IN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid3_reg <= 1'b0;
            rgb3_reg   <= '0;
            hit3_reg   <= '0;
        end else begin
            valid3_reg <= valid2_reg;
            if (valid2_reg) begin
                rgb3_reg <= scale_rgb(rgb2_reg, level_reg);
                hit3_reg <= hit2_reg;
            end
        end
    end

    assign pix_valid_o = valid3_reg;
    assign pix_rgb_o   = rgb3_reg;
    assign hit_layer_o = hit3_reg;
`else
    logic              unused_fade_cmd;
    localparam int     unused_fade_step = FADE_STEP;

    assign unused_fade_cmd = ^fade_cmd_i;
    assign fade_busy_o     = 1'b0;
    assign pix_valid_o     = valid2_reg;
    assign pix_rgb_o       = rgb2_reg;
    assign hit_layer_o     = hit2_reg;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed table, mask and reset
// sequences, fade sequences (when LAYER_FADE_EN is defined), random stream vs model.
module tb_layer_compositor;

    localparam int N    = 4;
    localparam int STEP = 2;
`ifdef LAYER_FADE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [23:0] TKEY = 24'hFF00FF;

    localparam int M_IDLE = 0, M_OUT = 1, M_DARK = 2, M_IN = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 frame_start;
    logic                 pix_valid_i;
    logic [N-1:0][23:0]   layers;
    logic [23:0]          bg;
    logic                 cfg_we;
    logic [N-1:0]         cfg_mask;
    logic [1:0]           fade_cmd;
    logic                 pix_valid_o;
    logic [23:0]          pix_rgb_o;
    logic [2:0]           hit_layer_o;
    logic                 fade_busy_o;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS (N),
        .FADE_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_valid_i (pix_valid_i),
        .layer_rgb_i (layers),
        .bg_rgb_i    (bg),
        .cfg_we      (cfg_we),
        .cfg_mask_i  (cfg_mask),
        .fade_cmd_i  (fade_cmd),
        .pix_valid_o (pix_valid_o),
        .pix_rgb_o   (pix_rgb_o),
        .hit_layer_o (hit_layer_o),
        .fade_busy_o (fade_busy_o)
    );

    typedef struct {
        logic        v;
        logic [23:0] rgb;
        int          hit;
    } exp_t;

    typedef struct {
        logic [23:0] l0, l1, l2, l3, bgc;
        logic [23:0] exp_rgb;
        int          exp_hit;
    } vec_t;

    exp_t        q[$];
    logic [N-1:0] m_shadow, m_active;
    int          m_lvl, m_st, m_fc;
    logic [23:0] m_last_rgb;
    int          m_last_hit;
    int          passed = 0;
    int          total  = 0;
    int          tick_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s (tick %0d): got %h, required %h", name, tick_no, act, req);
    endtask

    function automatic logic [23:0] scale(input logic [23:0] c, input int lvl);
        int r, g, b;
        r = (int'(c[23:16]) * (8 - lvl)) / 8;
        g = (int'(c[15:8])  * (8 - lvl)) / 8;
        b = (int'(c[7:0])   * (8 - lvl)) / 8;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic model_reset();
        exp_t e;
        m_shadow = '1; m_active = '1;
        m_lvl = 0; m_st = M_IDLE; m_fc = 0;
        m_last_rgb = '0; m_last_hit = 0;
        q.delete();
        e.v = 1'b0; e.rgb = '0; e.hit = 0;
        for (int i = 0; i < LAT - 1; i++) q.push_back(e);
    endtask

    // One clock: predict this cycle's pixel, advance the model, compare outputs.
    task automatic tick();
        exp_t         e;
        logic [N-1:0] eff;
        int           lvl_before;
        eff = frame_start ? (cfg_we ? cfg_mask : m_shadow) : m_active;
        e.v = pix_valid_i; e.rgb = bg; e.hit = N;
        for (int k = N - 1; k >= 0; k--)
            if (eff[k] && layers[k] != TKEY) begin e.rgb = layers[k]; e.hit = k; end
        q.push_back(e);
        @(posedge clk);
        tick_no++;
        lvl_before = m_lvl;
        if (cfg_we) m_shadow = cfg_mask;
        if (frame_start) begin
            m_active = eff;
`ifdef LAYER_FADE_EN
            case (m_st)
                M_IDLE: if (fade_cmd == 2'b01) begin m_st = M_OUT; m_fc = 0; end
                M_OUT: begin
                    m_fc++;
                    if (m_fc == STEP) begin
                        m_fc = 0; m_lvl++;
                        if (m_lvl == 8) m_st = M_DARK;
                    end
                end
                M_DARK: if (fade_cmd == 2'b10) begin m_st = M_IN; m_fc = 0; end
                default: begin
                    m_fc++;
                    if (m_fc == STEP) begin
                        m_fc = 0; m_lvl--;
                        if (m_lvl == 0) m_st = M_IDLE;
                    end
                end
            endcase
`endif
        end
        e = q.pop_front();
        if (e.v) begin
            m_last_rgb = scale(e.rgb, lvl_before);
            m_last_hit = e.hit;
        end
        #1;
        check("valid", 32'(pix_valid_o), 32'(e.v));
        check("rgb", 32'(pix_rgb_o), 32'(m_last_rgb));
        check("hit", 32'(hit_layer_o), 32'(m_last_hit));
        check("busy", 32'(fade_busy_o), 32'((m_st == M_OUT) || (m_st == M_IN)));
    endtask

    task automatic set_px(input logic [23:0] a, b, c, d, e);
        layers[0] = a; layers[1] = b; layers[2] = c; layers[3] = d; bg = e;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1; tick();
            frame_start = 1'b0; fade_cmd = 2'b00; tick(); tick();
        end
    endtask

    task automatic settle();
        for (int i = 0; i < LAT + 1; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, required done");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        int   cnt;

        vecs[0] = '{24'hFF00FF, 24'hE74C3C, 24'hFFCC00, 24'hFFCC00, 24'h000000, 24'hE74C3C, 1};
        vecs[1] = '{24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'h87CEEB, 24'h87CEEB, 4};
        vecs[2] = '{24'h7FC83F, 24'h55A02F, 24'hFFCC00, 24'h112233, 24'h87CEEB, 24'h7FC83F, 0};
        vecs[3] = '{24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'h123456, 24'h87CEEB, 24'h123456, 3};
        vecs[4] = '{24'hFF00FE, 24'hE74C3C, 24'hFF00FF, 24'hFF00FF, 24'h000001, 24'hFF00FE, 0};

        reset = 1'b1; frame_start = 1'b0; pix_valid_i = 1'b0; cfg_we = 1'b0;
        cfg_mask = '0; fade_cmd = 2'b00; set_px('0, '0, '0, '0, '0);
        model_reset();
        #1;
        check("reset_valid", 32'(pix_valid_o), 32'd0);
        check("reset_rgb", 32'(pix_rgb_o), 32'd0);
        check("reset_hit", 32'(hit_layer_o), 32'd0);
        check("reset_busy", 32'(fade_busy_o), 32'd0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;

        // Directed table with mask 1111
        pix_valid_i = 1'b1;
        foreach (vecs[i]) begin
            set_px(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3, vecs[i].bgc);
            for (int c = 0; c < LAT; c++) tick();
            check("table_rgb", 32'(pix_rgb_o), 32'(vecs[i].exp_rgb));
            check("table_hit", 32'(hit_layer_o), 32'(vecs[i].exp_hit));
        end

        // Mid-frame mask write only takes effect at the next frame_start
        set_px(24'h7FC83F, 24'h55A02F, 24'hFFCC00, 24'hFFCC00, 24'h000000);
        tick();
        cfg_we = 1'b1; cfg_mask = 4'b1110; tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("midframe_hold", 32'(pix_rgb_o), 32'h7FC83F);
        frame_start = 1'b1; tick();
        frame_start = 1'b0;
        check("pre_fs_pixel", 32'(pix_rgb_o), 32'h7FC83F);
        for (int i = 0; i < LAT - 1; i++) tick();
        check("fs_pixel_rgb", 32'(pix_rgb_o), 32'h55A02F);
        check("fs_pixel_hit", 32'(hit_layer_o), 32'd1);

        // Random stream against the model
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++)
                layers[k] = ($urandom_range(0, 1) == 0) ? TKEY : 24'($urandom);
            bg          = 24'($urandom);
            pix_valid_i = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_mask    = 4'($urandom);
            fade_cmd    = 2'($urandom);
            tick();
        end
        frame_start = 1'b0; cfg_we = 1'b0; fade_cmd = 2'b00;

        // Reset during a continuous valid stream
        pix_valid_i = 1'b1;
        set_px(24'h7FC83F, 24'h55A02F, 24'hFFCC00, 24'hFFCC00, 24'h000000);
        for (int i = 0; i < 4; i++) tick();
        #2 reset = 1'b1;
        #1 check("reset_async_valid", 32'(pix_valid_o), 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!pix_valid_o && cnt < 10);
        check("reset_latency", 32'(cnt), 32'(LAT));

        // Each mask bit is back to 1 after reset
        for (int k = 0; k < N; k++) begin
            set_px(TKEY, TKEY, TKEY, TKEY, 24'h87CEEB);
            layers[k] = 24'h204060 + 24'(k);
            for (int c = 0; c < LAT; c++) tick();
            check("mask_bit", 32'(hit_layer_o), 32'(k));
        end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        settle();
        check("shadow_ones", 32'(hit_layer_o), 32'd3);

        // Fade sequences on a winning layer of E74C3C
        set_px(TKEY, 24'hE74C3C, 24'hFFCC00, 24'hFFCC00, 24'h000000);
        settle();
        frame_start = 1'b1; fade_cmd = 2'b01; tick();
        frame_start = 1'b0; fade_cmd = 2'b00; tick();
`ifdef LAYER_FADE_EN
        frames(8); settle();
        check("fade_lvl4_rgb", 32'(pix_rgb_o), 32'h73261E);
        check("fade_lvl4_busy", 32'(fade_busy_o), 32'd1);
        frames(8); settle();
        check("dark_rgb", 32'(pix_rgb_o), 32'h000000);
        check("dark_busy", 32'(fade_busy_o), 32'd0);
        frame_start = 1'b1; fade_cmd = 2'b10; tick();
        frame_start = 1'b0; fade_cmd = 2'b00; tick();
        frames(3);
        fade_cmd = 2'b01; frames(1);
        frames(4); settle();
        check("fadein_lvl4_rgb", 32'(pix_rgb_o), 32'h73261E);
        check("fadein_busy", 32'(fade_busy_o), 32'd1);
        frames(8); settle();
        check("fadein_done_rgb", 32'(pix_rgb_o), 32'hE74C3C);
        check("fadein_done_busy", 32'(fade_busy_o), 32'd0);
`else
        frames(8); settle();
        check("nofade_rgb", 32'(pix_rgb_o), 32'hE74C3C);
        check("nofade_busy", 32'(fade_busy_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
